// File: rtl/lsu.sv
// Load/store unit between a request port and a single-port-style data memory with byte enables.
// Optional build macro LSU_MISALIGN_TRAP_EN: misaligned accesses complete with rsp_err instead of being aligned down.
module lsu (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic [14:0] mem_rdaddress,
  output logic [14:0] mem_wraddress,
  output logic        mem_wren,
  output logic [3:0]  mem_byteena,
  output logic [31:0] mem_data,
  input  logic [31:0] mem_q
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ST      = 3'd1,
    LD_ADDR = 3'd2,
`ifdef LSU_MISALIGN_TRAP_EN
    LD_DATA = 3'd3,
    ERR     = 3'd4
`else
    LD_DATA = 3'd3
`endif
  } state_t;

  state_t      state_reg, state_next;
  logic [1:0]  size_reg;
  logic [1:0]  off_reg;
  logic        unsigned_reg;
  logic [3:0]  be_reg;
  logic [31:0] wdata_reg;
  logic [14:0] wraddr_reg;
  logic [14:0] rdaddr_reg;

  logic        accept;
  logic        req_bad;
  logic [1:0]  req_off;
  logic [1:0]  eff_size;
  logic [1:0]  eff_off;
  logic [3:0]  lane_en;
  logic [31:0] lane_data;
  logic [31:0] load_shift;
  logic [31:0] load_data;
  logic        unused_addr;

  assign unused_addr = ^req_addr[31:17];
  assign req_off     = req_addr[1:0];
  assign req_ready   = (state_reg == IDLE);
  assign accept      = req_valid && req_ready;

`ifdef LSU_MISALIGN_TRAP_EN
  assign eff_size = req_size;
  assign eff_off  = req_off;
  assign req_bad  = (req_size == 2'b11) ||
                    ((req_size == 2'b01) && req_off[0]) ||
                    ((req_size == 2'b10) && (req_off != 2'b00));
`else
  // Misaligned requests are silently aligned down; size 11 behaves as a word.
  assign eff_size = (req_size == 2'b11) ? 2'b10 : req_size;
  assign eff_off  = (req_size == 2'b00) ? req_off :
                    (req_size == 2'b01) ? {req_off[1], 1'b0} : 2'b00;
  assign req_bad  = 1'b0;
`endif

  // Per-lane store enable and data: narrow stores are replicated across the word.
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      localparam logic [1:0] LANE = 2'(gi);
      assign lane_en[gi] = (eff_size == 2'b00) ? (eff_off == LANE) :
                           (eff_size == 2'b01) ? (eff_off[1] == LANE[1]) : 1'b1;
      assign lane_data[8*gi +: 8] = (eff_size == 2'b00) ? req_wdata[7:0] :
                                    (eff_size == 2'b01) ? req_wdata[8*(gi%2) +: 8] :
                                                          req_wdata[8*gi +: 8];
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_reg    <= IDLE;
      size_reg     <= 2'b00;
      off_reg      <= 2'b00;
      unsigned_reg <= 1'b0;
      be_reg       <= 4'b0000;
      wdata_reg    <= 32'h0;
      wraddr_reg   <= 15'h0;
      rdaddr_reg   <= 15'h0;
    end else begin
      state_reg <= state_next;
      if (accept) begin
        size_reg     <= eff_size;
        off_reg      <= eff_off;
        unsigned_reg <= req_unsigned;
        if (req_we) begin
          be_reg     <= lane_en;
          wdata_reg  <= lane_data;
          wraddr_reg <= req_addr[16:2];
        end else if (!req_bad) begin
          // Read address only moves for a load that really issues.
          rdaddr_reg <= req_addr[16:2];
        end
      end
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        if (accept) begin
`ifdef LSU_MISALIGN_TRAP_EN
          if (req_bad)     state_next = ERR;
          else if (req_we) state_next = ST;
          else             state_next = LD_ADDR;
`else
          state_next = req_we ? ST : LD_ADDR;
`endif
        end
      end
      ST:      state_next = IDLE;
      LD_ADDR: state_next = LD_DATA;
      LD_DATA: state_next = IDLE;
`ifdef LSU_MISALIGN_TRAP_EN
      ERR:     state_next = IDLE;
`endif
      default: state_next = IDLE;
    endcase
  end

  assign load_shift = mem_q >> {off_reg, 3'b000};

  always_comb begin
    load_data = load_shift;
    case (size_reg)
      2'b00:   load_data = unsigned_reg ? {24'h0, load_shift[7:0]}
                                        : {{24{load_shift[7]}}, load_shift[7:0]};
      2'b01:   load_data = unsigned_reg ? {16'h0, load_shift[15:0]}
                                        : {{16{load_shift[15]}}, load_shift[15:0]};
      default: load_data = load_shift;
    endcase
  end

  // Responses and write strobe are qualified by rst so an access caught by reset leaves no trace.
  always_comb begin
    rsp_valid   = 1'b0;
    rsp_err     = 1'b0;
    rsp_rdata   = 32'h0;
    mem_wren    = 1'b0;
    mem_byteena = 4'b0000;
    if (rst) begin
      case (state_reg)
        ST: begin
          mem_wren    = 1'b1;
          mem_byteena = be_reg;
          rsp_valid   = 1'b1;
        end
        LD_DATA: begin
          rsp_valid = 1'b1;
          rsp_rdata = load_data;
        end
`ifdef LSU_MISALIGN_TRAP_EN
        ERR: begin
          rsp_valid = 1'b1;
          rsp_err   = 1'b1;
        end
`endif
        default: ;
      endcase
    end
  end

  assign mem_rdaddress = rdaddr_reg;
  assign mem_wraddress = wraddr_reg;
  assign mem_data      = wdata_reg;

endmodule

// File: tb/tb_lsu.sv
// Directed self-checking bench for lsu with a behavioural byte-enabled memory behind it.
module tb_lsu;
  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [31:0] req_addr;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic [14:0] mem_rdaddress;
  logic [14:0] mem_wraddress;
  logic        mem_wren;
  logic [3:0]  mem_byteena;
  logic [31:0] mem_data;
  logic [31:0] mem_q;

  logic [31:0] mem [0:32767];

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  lsu dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_size(req_size), .req_unsigned(req_unsigned),
    .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .mem_rdaddress(mem_rdaddress), .mem_wraddress(mem_wraddress),
    .mem_wren(mem_wren), .mem_byteena(mem_byteena), .mem_data(mem_data),
    .mem_q(mem_q)
  );

  always @(posedge clk) begin
    for (int b = 0; b < 4; b++)
      if (mem_wren && mem_byteena[b])
        mem[mem_wraddress][8*b +: 8] <= mem_data[8*b +: 8];
    mem_q <= mem[mem_rdaddress];
  end

  // Presents a request and returns 1 time unit after the edge that accepted it.
  task automatic issue(input logic we, input logic [31:0] addr, input logic [1:0] size,
                       input logic uns, input logic [31:0] wdata);
    req_we = we; req_addr = addr; req_size = size; req_unsigned = uns; req_wdata = wdata;
    req_valid = 1'b1;
    for (int n = 0; n < 8 && !req_ready; n++) begin
      @(posedge clk); #1;
    end
    if (req_ready !== 1'b1) begin
      total++;
      $display("FAIL issue_ready got %b exp 1", req_ready);
    end
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  task automatic do_store(input logic [31:0] addr, input logic [1:0] size, input logic [31:0] wdata,
                          output logic wren, output logic [3:0] be, output logic [14:0] wa,
                          output logic [31:0] wd, output logic v, output logic e);
    issue(1'b1, addr, size, 1'b0, wdata);
    wren = mem_wren; be = mem_byteena; wa = mem_wraddress; wd = mem_data;
    v = rsp_valid; e = rsp_err;
    @(posedge clk); #1;
  endtask

  task automatic do_load(input logic [31:0] addr, input logic [1:0] size, input logic uns,
                         output logic early_v, output logic v, output logic [31:0] d);
    issue(1'b0, addr, size, uns, 32'h0);
    early_v = rsp_valid;
    @(posedge clk); #1;
    v = rsp_valid; d = rsp_rdata;
    @(posedge clk); #1;
  endtask

  task automatic test_reset;
    rst = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_addr = '0;
    req_size = 2'b00; req_unsigned = 1'b0; req_wdata = '0;
    repeat (2) @(posedge clk);
    #1;
    total++;
    if ({rsp_valid, rsp_err, mem_wren, mem_byteena} !== 7'b0) $display("FAIL reset_ctrl got %b exp 0", {rsp_valid, rsp_err, mem_wren, mem_byteena});
    else passed++;
    total++;
    if (rsp_rdata !== 32'h0) $display("FAIL reset_rdata got %h exp 0", rsp_rdata); else passed++;
    total++;
    if (mem_data !== 32'h0) $display("FAIL reset_mem_data got %h exp 0", mem_data); else passed++;
    total++;
    if ({mem_rdaddress, mem_wraddress} !== 30'h0) $display("FAIL reset_addr got %h/%h exp 0", mem_rdaddress, mem_wraddress);
    else passed++;
    rst = 1'b1;
    @(posedge clk); #1;
    total++;
    if (req_ready !== 1'b1) $display("FAIL reset_ready got %b exp 1", req_ready); else passed++;
  endtask

  task automatic test_word;
    logic wren, v, e, ev; logic [3:0] be; logic [14:0] wa; logic [31:0] wd, d;
    do_store(32'h0000_0010, 2'b10, 32'h1122_3344, wren, be, wa, wd, v, e);
    total++;
    if ({wren, be, v, e} !== 7'b1_1111_1_0) $display("FAIL word_st_ctrl got %b exp 1111110", {wren, be, v, e}); else passed++;
    total++;
    if (wa !== 15'd4 || wd !== 32'h1122_3344) $display("FAIL word_st_addr got %0d/%h exp 4/11223344", wa, wd); else passed++;
    do_load(32'h0000_0010, 2'b10, 1'b0, ev, v, d);
    total++;
    if (ev !== 1'b0 || v !== 1'b1 || d !== 32'h1122_3344) $display("FAIL word_ld got %b%b/%h exp 01/11223344", ev, v, d); else passed++;
    total++;
    if (mem_rdaddress !== 15'd4) $display("FAIL word_ld_hold got %0d exp 4", mem_rdaddress); else passed++;
  endtask

  task automatic test_byte;
    logic wren, v, e, ev; logic [3:0] be; logic [14:0] wa; logic [31:0] wd, d;
    do_store(32'h0000_0013, 2'b00, 32'h0000_0080, wren, be, wa, wd, v, e);
    total++;
    if (be !== 4'b1000 || wd !== 32'h8080_8080 || wa !== 15'd4) $display("FAIL byte_st got %b/%h/%0d exp 1000/80808080/4", be, wd, wa); else passed++;
    do_load(32'h0000_0013, 2'b00, 1'b0, ev, v, d);
    total++;
    if (v !== 1'b1 || d !== 32'hFFFF_FF80) $display("FAIL byte_ld_s got %b/%h exp 1/ffffff80", v, d); else passed++;
    do_load(32'h0000_0013, 2'b00, 1'b1, ev, v, d);
    total++;
    if (v !== 1'b1 || d !== 32'h0000_0080) $display("FAIL byte_ld_u got %b/%h exp 1/00000080", v, d); else passed++;
    do_load(32'h0000_0011, 2'b00, 1'b1, ev, v, d);
    total++;
    if (d !== 32'h0000_0033) $display("FAIL byte_ld_off1 got %h exp 00000033", d); else passed++;
  endtask

  task automatic test_half;
    logic wren, v, e, ev; logic [3:0] be; logic [14:0] wa; logic [31:0] wd, d;
    do_store(32'h0000_0020, 2'b10, 32'hBEEF_1234, wren, be, wa, wd, v, e);
    do_load(32'h0000_0022, 2'b01, 1'b0, ev, v, d);
    total++;
    if (d !== 32'hFFFF_BEEF) $display("FAIL half_ld_s got %h exp ffffbeef", d); else passed++;
    do_load(32'h0000_0022, 2'b01, 1'b1, ev, v, d);
    total++;
    if (d !== 32'h0000_BEEF) $display("FAIL half_ld_u got %h exp 0000beef", d); else passed++;
    do_load(32'h0000_0020, 2'b01, 1'b0, ev, v, d);
    total++;
    if (d !== 32'h0000_1234) $display("FAIL half_ld_lo got %h exp 00001234", d); else passed++;
    do_store(32'h0000_0032, 2'b01, 32'h0000_5AA5, wren, be, wa, wd, v, e);
    total++;
    if (be !== 4'b1100 || wd !== 32'h5AA5_5AA5 || wa !== 15'd12) $display("FAIL half_st got %b/%h/%0d exp 1100/5aa55aa5/12", be, wd, wa); else passed++;
    do_load(32'h0000_0032, 2'b01, 1'b1, ev, v, d);
    total++;
    if (d !== 32'h0000_5AA5) $display("FAIL half_st_rb got %h exp 00005aa5", d); else passed++;
  endtask

  task automatic test_misalign;
    logic wren, v, e, ev; logic [3:0] be; logic [14:0] wa; logic [31:0] wd, d;
    do_store(32'h0000_0004, 2'b10, 32'h0102_0304, wren, be, wa, wd, v, e);
`ifdef LSU_MISALIGN_TRAP_EN
    do_store(32'h0000_0006, 2'b10, 32'hCAFE_F00D, wren, be, wa, wd, v, e);
    total++;
    if ({v, e, wren, be} !== 7'b1_1_0_0000) $display("FAIL mis_err got %b exp 1100000", {v, e, wren, be}); else passed++;
    do_load(32'h0000_0004, 2'b10, 1'b0, ev, v, d);
    total++;
    if (d !== 32'h0102_0304) $display("FAIL mis_unchanged got %h exp 01020304", d); else passed++;
    do_load(32'h0000_0005, 2'b01, 1'b0, ev, v, d);
    total++;
    if (v !== 1'b0 || d !== 32'h0) $display("FAIL mis_ld_err got %b/%h exp 0/0 (err came a cycle early)", v, d); else passed++;
`else
    do_store(32'h0000_0006, 2'b10, 32'hCAFE_F00D, wren, be, wa, wd, v, e);
    total++;
    if ({v, e, wren, be} !== 7'b1_0_1_1111 || wa !== 15'd1) $display("FAIL mis_align got %b/%0d exp 1011111/1", {v, e, wren, be}, wa); else passed++;
    do_load(32'h0000_0007, 2'b10, 1'b0, ev, v, d);
    total++;
    if (d !== 32'hCAFE_F00D) $display("FAIL mis_ld_word got %h exp cafef00d", d); else passed++;
    do_load(32'h0000_0023, 2'b01, 1'b1, ev, v, d);
    total++;
    if (d !== 32'h0000_BEEF) $display("FAIL mis_ld_half got %h exp 0000beef", d); else passed++;
`endif
  endtask

  task automatic test_reset_in_st;
    logic ev, v; logic [31:0] d;
    int seen_wren = 0;
    int seen_valid = 0;
    req_we = 1'b1; req_addr = 32'h0000_0010; req_size = 2'b10; req_wdata = 32'hDEAD_BEEF;
    req_valid = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; req_valid = 1'b0;
    @(negedge clk);
    if (mem_wren) seen_wren++;
    if (rsp_valid) seen_valid++;
    @(posedge clk); #1;
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (mem_wren) seen_wren++;
      if (rsp_valid) seen_valid++;
    end
    total++;
    if (seen_wren != 0 || seen_valid != 0) $display("FAIL rst_st_quiet got wren=%0d valid=%0d exp 0/0", seen_wren, seen_valid); else passed++;
    @(posedge clk); #1;
    do_load(32'h0000_0010, 2'b10, 1'b0, ev, v, d);
    total++;
    if (d !== 32'h8022_3344) $display("FAIL rst_st_mem got %h exp 80223344", d); else passed++;
  endtask

  task automatic test_back_to_back;
    int rsp_count = 0;
    req_we = 1'b0; req_addr = 32'h0000_0020; req_size = 2'b10; req_unsigned = 1'b0;
    req_valid = 1'b1;
    for (int i = 0; i < 9; i++) begin
      total++;
      if (req_ready !== (i % 3 == 0)) $display("FAIL b2b_ready[%0d] got %b exp %b", i, req_ready, (i % 3 == 0));
      else passed++;
      if (rsp_valid === 1'b1) begin
        rsp_count++;
        total++;
        if (rsp_rdata !== 32'hBEEF_1234) $display("FAIL b2b_data[%0d] got %h exp beef1234", i, rsp_rdata); else passed++;
      end
      @(posedge clk); #1;
    end
    req_valid = 1'b0;
    total++;
    if (rsp_count != 3) $display("FAIL b2b_count got %0d exp 3", rsp_count); else passed++;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_word();
    test_byte();
    test_half();
    test_misalign();
    test_reset_in_st();
    test_back_to_back();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
